// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch queue slice.
//   NOP_INSTR     - instruction word presented when no entry is valid
//   INSTR_BYTES   - address increment between sequential fetches
//   fetch_entry_t - one queued instruction with the PC it was fetched from
package fetch_pkg;

   localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
   localparam int          INSTR_BYTES = 4;

   // pc sits in the upper half so a packed entry matches {pc, instr}
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush.
//   clk, reset       - rising-edge clock, async active-high reset
//   push, push_data  - write an entry (accepted when not full, or when full
//                      with a simultaneous pop)
//   pop              - discard the head entry (ignored when empty)
//   flush            - empty the FIFO at the next edge, dominates push/pop
//   pop_data         - current head entry (undefined content when empty)
//   full, empty      - occupancy flags
//   count            - number of stored entries, 0..DEPTH
module sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   // a push into a full FIFO is only legal when the head leaves the same cycle
   assign do_push  = push && (!full || pop);
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap on their own
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // storage needs no reset; count and pointers define what is valid
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fetch_queue.sv
// Sequential instruction fetch with a small in-order instruction queue.
//   clk, reset                      - rising-edge clock, async active-high reset
//   imem_req_valid/ready/addr       - request channel to instruction memory
//   imem_rsp_valid/data             - in-order responses, one per accepted
//                                     request, no back-pressure
//   redirect_valid, redirect_pc     - flush everything and restart fetching
//   instr_valid/ready, instr, pc    - queue head toward decode
// Issue is throttled so that buffered entries plus in-flight requests never
// exceed DEPTH; every response therefore always has a slot waiting for it.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter int              DEPTH    = 4
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] pc
);

   localparam int              CW        = $clog2(DEPTH) + 1;
   localparam logic [CW:0]     DEPTH_LIM = (CW + 1)'(DEPTH);
   localparam logic [XLEN-1:0] STEP      = XLEN'(INSTR_BYTES);

   logic [XLEN-1:0]   fetch_pc;
   logic [XLEN-1:0]   rsp_pc;
   logic [CW-1:0]     outstanding;
   logic [CW-1:0]     outstanding_next;
   logic [CW-1:0]     discard;
   logic [CW-1:0]     count;
   logic [CW:0]       reserved;
   logic [XLEN-1:0]   redirect_base;
   logic [2*XLEN-1:0] head;
   logic              req_fire;
   logic              drop;
   logic              push;
   logic              pop;
   logic              full;
   logic              empty;

   assign reserved       = {1'b0, count} + {1'b0, outstanding};
   assign imem_req_valid = !reset && !redirect_valid && (reserved < DEPTH_LIM);
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign redirect_base  = {redirect_pc[XLEN-1:2], 2'b00};

   // responses owed to a flushed stream are swallowed while discard is nonzero;
   // a response landing in the redirect cycle itself is never pushed either
   assign drop             = (discard != '0);
   assign push             = imem_rsp_valid && !drop && !redirect_valid;
   assign pop              = instr_valid && instr_ready;
   assign outstanding_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

   sync_fifo #(
      .WIDTH (2 * XLEN),
      .DEPTH (DEPTH)
   ) entries (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data ({rsp_pc, imem_rsp_data}),
      .pop       (pop),
      .flush     (redirect_valid),
      .pop_data  (head),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   // on redirect every request still in flight after this edge is stale,
   // so discard is loaded with the post-edge outstanding count
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         outstanding <= outstanding_next;
         if (redirect_valid) begin
            fetch_pc <= redirect_base;
            rsp_pc   <= redirect_base;
            discard  <= outstanding_next;
         end else begin
            if (req_fire)              fetch_pc <= fetch_pc + STEP;
            if (push)                  rsp_pc   <= rsp_pc + STEP;
            if (imem_rsp_valid && drop) discard <= discard - CW'(1);
         end
      end
   end

   assign instr_valid = !empty;
   assign instr       = empty ? XLEN'(NOP_INSTR) : head[XLEN-1:0];
   assign pc          = empty ? '0 : head[2*XLEN-1:XLEN];

   a_no_overflow : assert property (@(posedge clk) disable iff (reset)
      !(push && full && !pop));
   a_reservation : assert property (@(posedge clk) disable iff (reset)
      reserved <= DEPTH_LIM);
   a_no_orphan_rsp : assert property (@(posedge clk) disable iff (reset)
      !(imem_rsp_valid && outstanding == '0));

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios with literal
// expectations plus a randomized run, all compared every cycle against a
// request-list model of the fetch stream.
module tb_fetch_queue;
   import fetch_pkg::*;

   localparam int          XLEN     = 32;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] SALT     = 32'hA5A5_0000;

   logic        clk;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] pc;

   int checks_total  = 0;
   int checks_passed = 0;

   fetch_queue #(
      .XLEN     (XLEN),
      .RESET_PC (RESET_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .pc             (pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks_total++;
      if (actual === expected) checks_passed++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
   endtask

   // Memory: accepts every offered request, answers in order after a
   // per-request latency of lat_min..lat_max cycles with addr ^ SALT.
   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   mreq_t mem_q[$];
   int    cyc       = 0;
   int    last_due  = 0;
   int    due       = 0;
   int    lat_min   = 1;
   int    lat_max   = 1;
   int    req_count = 0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q.delete();
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
         last_due       = cyc;
      end else begin
         cyc++;
         if (imem_req_valid && imem_req_ready) begin
            req_count++;
            due = cyc + $urandom_range(lat_max, lat_min) - 1;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q.push_back('{addr: imem_req_addr, due: due});
         end
         #1;
         if (!reset && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_q[0].addr ^ SALT;
            void'(mem_q.pop_front());
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
         end
      end
   end

   // Reference model: a list of requested addresses, each marked stale once
   // a redirect overtakes it, and the list of instructions visible to decode.
   typedef struct {
      logic [31:0] addr;
      bit          stale;
   } flight_t;

   flight_t      m_flight[$];
   fetch_entry_t m_q[$];
   logic [31:0]  m_fetch_pc = RESET_PC;
   bit           m_fire;
   flight_t      m_f;

   function automatic bit m_req_valid();
      return !redirect_valid && (m_q.size() + m_flight.size() < DEPTH);
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_q.delete();
         m_flight.delete();
         m_fetch_pc = RESET_PC;
      end else begin
         m_fire = m_req_valid() && imem_req_ready;
         if (m_q.size() > 0 && instr_ready) void'(m_q.pop_front());
         if (imem_rsp_valid) begin
            if (m_flight.size() == 0) begin
               checks_total++;
               $display("[TB] FAIL rsp_without_request: got response, expected none in flight");
            end else begin
               m_f = m_flight.pop_front();
               if (!m_f.stale && !redirect_valid)
                  m_q.push_back('{pc: m_f.addr, instr: imem_rsp_data});
            end
         end
         if (redirect_valid) begin
            m_q.delete();
            foreach (m_flight[i]) m_flight[i].stale = 1'b1;
            m_fetch_pc = {redirect_pc[31:2], 2'b00};
         end else if (m_fire) begin
            m_flight.push_back('{addr: m_fetch_pc, stale: 1'b0});
            m_fetch_pc = m_fetch_pc + 32'd4;
         end
      end
   end

   // Every out-of-reset cycle, all outputs are compared against the model.
   always @(negedge clk) begin
      if (!reset) begin
         check_output("req_valid", {31'b0, imem_req_valid}, {31'b0, m_req_valid()});
         check_output("req_addr", imem_req_addr, m_fetch_pc);
         check_output("instr_valid", {31'b0, instr_valid}, {31'b0, m_q.size() > 0});
         if (m_q.size() > 0) begin
            check_output("head_pc", pc, m_q[0].pc);
            check_output("head_instr", instr, m_q[0].instr);
         end else begin
            check_output("idle_pc", pc, 32'h0);
            check_output("idle_instr", instr, NOP_INSTR);
         end
      end
   end

   // Record every PC handed to decode, for the directed sequence checks.
   logic [31:0] popped[$];

   always @(posedge clk) begin
      if (!reset && instr_valid && instr_ready) popped.push_back(pc);
   end

   task automatic apply_stimulus(input bit req_ready, input bit dec_ready,
                                 input bit redir, input logic [31:0] redir_pc);
      imem_req_ready = req_ready;
      instr_ready    = dec_ready;
      redirect_valid = redir;
      redirect_pc    = redir_pc;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_output({tag, "_instr_valid"}, {31'b0, instr_valid}, 32'h0);
      check_output({tag, "_instr"}, instr, NOP_INSTR);
      check_output({tag, "_pc"}, pc, 32'h0);
      check_output({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'h0);
      check_output({tag, "_req_addr"}, imem_req_addr, RESET_PC);
   endtask

   task automatic do_reset(input bit req_ready, input bit dec_ready, input int lmin,
                           input int lmax);
      next_cycle();
      reset = 1'b1;
      apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
      lat_min = lmin;
      lat_max = lmax;
      repeat (2) next_cycle();
      apply_stimulus(req_ready, dec_ready, 1'b0, 32'h0);
      req_count = 0;
      popped.delete();
      reset = 1'b0;
   endtask

   task automatic check_popped(input string name, input int idx, input logic [31:0] exp_pc);
      check_output(name, (idx < popped.size()) ? popped[idx] : 32'hDEAD_BEEF, exp_pc);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1;
      apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
      #2;
      check_reset_outputs("in_reset");

      // Zero-wait memory: stream 0,4,8,12 from the second cycle after release.
      repeat (2) @(posedge clk);
      #1;
      apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_output("stream_valid", {31'b0, instr_valid}, 32'h1);
         check_output("stream_pc", pc, 32'(4 * i));
         check_output("stream_instr", instr, 32'(4 * i) ^ SALT);
      end

      // Decode stall: exactly DEPTH requests, then issue stops until drained.
      do_reset(1'b1, 1'b0, 1, 1);
      repeat (10) next_cycle();
      @(negedge clk);
      check_output("stall_req_count", 32'(req_count), 32'd4);
      check_output("stall_req_valid", {31'b0, imem_req_valid}, 32'h0);
      check_output("stall_head_pc", pc, 32'h0);
      next_cycle();
      instr_ready = 1'b1;
      repeat (10) next_cycle();
      for (int i = 0; i < 5; i++) check_popped("stall_drain_pc", i, 32'(4 * i));

      // 3-cycle memory: redirect with two requests in flight.
      do_reset(1'b1, 1'b1, 3, 3);
      next_cycle();
      next_cycle();
      apply_stimulus(1'b0, 1'b1, 1'b1, 32'h0000_0100);
      next_cycle();
      apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (instr_valid) break;
      end
      check_output("latency_redirect_valid", {31'b0, instr_valid}, 32'h1);
      check_output("latency_redirect_pc", pc, 32'h0000_0100);
      repeat (6) next_cycle();
      check_popped("latency_first_popped", 0, 32'h0000_0100);
      check_popped("latency_second_popped", 1, 32'h0000_0104);

      // Redirect in the same cycle as a response and a pop; unaligned target.
      do_reset(1'b1, 1'b1, 1, 1);
      repeat (5) next_cycle();
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #2;
         if (imem_rsp_valid && instr_valid) break;
      end
      check_output("concurrent_setup", {31'b0, imem_rsp_valid && instr_valid}, 32'h1);
      apply_stimulus(1'b1, 1'b1, 1'b1, 32'h0000_0103);
      next_cycle();
      apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
      popped.delete();
      @(negedge clk);
      check_output("concurrent_flushed", {31'b0, instr_valid}, 32'h0);
      repeat (6) next_cycle();
      check_popped("concurrent_first_pc", 0, 32'h0000_0100);
      check_popped("concurrent_second_pc", 1, 32'h0000_0104);

      // Address wrap at the top of the address space.
      apply_stimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
      next_cycle();
      apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
      popped.delete();
      repeat (8) next_cycle();
      check_popped("wrap_pc0", 0, 32'hFFFF_FFF8);
      check_popped("wrap_pc1", 1, 32'hFFFF_FFFC);
      check_popped("wrap_pc2", 2, 32'h0000_0000);

      // Asynchronous reset between edges, then restart at RESET_PC.
      repeat (3) next_cycle();
      #2;
      reset = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      repeat (2) next_cycle();
      popped.delete();
      req_count = 0;
      reset = 1'b0;
      repeat (6) next_cycle();
      check_popped("restart_pc0", 0, RESET_PC);
      check_popped("restart_pc1", 1, RESET_PC + 32'd4);

      // Randomized traffic: stalls on both sides, variable latency, redirects.
      do_reset(1'b1, 1'b1, 1, 4);
      for (int i = 0; i < 3000; i++) begin
         apply_stimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                        $urandom_range(0, 31) == 0, $urandom);
         next_cycle();
      end
      apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
      repeat (10) next_cycle();

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
